// File: rtl/uart_pkg.sv
// Shared types for the UART datapath.
// Frame FSM states, parity modes and error bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11
   } parity_mode_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   localparam int ERR_FRAME    = 0;
   localparam int ERR_PARITY   = 1;
   localparam int ERR_OVERFLOW = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO, power-of-two depth.
// A push into a full FIFO is taken only when a pop happens in the same clk.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     nReset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART: baud tick, TX/RX frame FSMs, FIFOs,
// RTS/CTS flow control and sticky error flags.
module uart_fifo_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [1:0]           parity_mode,
   input  logic [DATA_BITS-1:0] tx_wdata,
   input  logic                 tx_wvalid,
   output logic                 tx_wready,
   output logic [DATA_BITS-1:0] rx_rdata,
   output logic                 rx_rvalid,
   input  logic                 rx_rready,
   input  logic                 rx,
   output logic                 tx,
   input  logic                 cts,
   output logic                 rts,
   output logic [2:0]           err_status,
   input  logic                 err_clr
);

   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] RTS_MAX  = CNT_W'(FIFO_DEPTH - 2);

   logic                 up_q;
   logic                 rts_q;
   logic [1:0]           rx_meta;
   logic [1:0]           cts_meta;
   logic                 rx_s;
   logic                 rx_s_d;
   logic                 cts_s;
   logic [DIV_W-1:0]     tick_cnt;
   logic                 tick;
   parity_mode_t         pm;
   logic                 par_en;
   logic                 par_odd;

   logic                 tx_push;
   logic                 tx_pop;
   logic [DATA_BITS-1:0] tx_head;
   logic                 tx_full;
   logic                 tx_empty;
   logic [CNT_W-1:0]     tx_count;
   logic                 unused_tx_count;

   logic                 rx_good;
   logic                 rx_stop_smp;
   logic                 rx_full;
   logic                 rx_empty;
   logic [CNT_W-1:0]     rx_count;

   tx_state_t            tx_state;
   logic [OS_W-1:0]      tx_os;
   logic [BIT_W-1:0]     tx_bit;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_par;
   logic                 tx_q;

   rx_state_t            rx_state;
   logic [OS_W-1:0]      rx_os;
   logic [BIT_W-1:0]     rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_par_err;

   logic [2:0]           err_q;
   logic [2:0]           err_set;

   assign pm      = parity_mode_t'(parity_mode);
   assign par_en  = (pm == PAR_EVEN) | (pm == PAR_ODD);
   assign par_odd = (pm == PAR_ODD);
   assign rx_s    = rx_meta[1];
   assign cts_s   = cts_meta[1];
   assign tick    = (tick_cnt >= baud_div);

   assign tx_wready  = up_q & ~tx_full;
   assign tx_push    = tx_wvalid & tx_wready;
   assign tx_pop     = tick & (tx_state == TX_IDLE) & ~tx_empty & cts_s;
   assign tx         = tx_q;
   assign rts        = rts_q;
   assign rx_rvalid  = ~rx_empty;
   assign err_status = err_q;

   assign unused_tx_count = ^tx_count;

   assign rx_stop_smp = tick & (rx_state == RX_STOP) & (rx_os == OS_LAST);
   assign rx_good     = rx_stop_smp & rx_s & ~rx_par_err;

   always_comb begin
      err_set               = '0;
      err_set[ERR_FRAME]    = rx_stop_smp & ~rx_s;
      err_set[ERR_PARITY]   = rx_stop_smp & rx_par_err;
      err_set[ERR_OVERFLOW] = rx_good & rx_full & ~rx_rready;
   end

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk    (clk),
      .nReset (nReset),
      .push   (tx_push),
      .pop    (tx_pop),
      .wdata  (tx_wdata),
      .rdata  (tx_head),
      .full   (tx_full),
      .empty  (tx_empty),
      .count  (tx_count)
   );

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk    (clk),
      .nReset (nReset),
      .push   (rx_good),
      .pop    (rx_rready),
      .wdata  (rx_shift),
      .rdata  (rx_rdata),
      .full   (rx_full),
      .empty  (rx_empty),
      .count  (rx_count)
   );

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         up_q     <= 1'b0;
         rts_q    <= 1'b0;
         rx_meta  <= 2'b11;
         rx_s_d   <= 1'b1;
         cts_meta <= 2'b00;
         tick_cnt <= '0;
         err_q    <= '0;
      end else begin
         up_q     <= 1'b1;
         rts_q    <= (rx_count <= RTS_MAX);
         rx_meta  <= {rx_meta[0], rx};
         rx_s_d   <= rx_s;
         cts_meta <= {cts_meta[0], cts};
         tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
         err_q    <= (err_clr ? 3'b000 : err_q) | err_set;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         tx_state <= TX_IDLE;
         tx_os    <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx_q     <= 1'b1;
      end else if (tick) begin
         unique case (tx_state)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_state <= TX_START;
                  tx_os    <= '0;
                  tx_shift <= tx_head;
                  tx_par   <= ^tx_head ^ par_odd;
                  tx_q     <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_os == OS_LAST) begin
                  tx_state <= TX_DATA;
                  tx_os    <= '0;
                  tx_bit   <= '0;
                  tx_q     <= tx_shift[0];
               end else begin
                  tx_os <= tx_os + OS_W'(1);
               end
            end
            TX_DATA: begin
               if (tx_os == OS_LAST) begin
                  tx_os <= '0;
                  if (tx_bit == BIT_LAST) begin
                     tx_state <= par_en ? TX_PARITY : TX_STOP;
                     tx_q     <= par_en ? tx_par : 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + BIT_W'(1);
                     tx_shift <= tx_shift >> 1;
                     tx_q     <= tx_shift[1];
                  end
               end else begin
                  tx_os <= tx_os + OS_W'(1);
               end
            end
            TX_PARITY: begin
               if (tx_os == OS_LAST) begin
                  tx_state <= TX_STOP;
                  tx_os    <= '0;
                  tx_q     <= 1'b1;
               end else begin
                  tx_os <= tx_os + OS_W'(1);
               end
            end
            TX_STOP: begin
               if (tx_os == OS_LAST)
                  tx_state <= TX_IDLE;
               else
                  tx_os <= tx_os + OS_W'(1);
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Start detect runs every clk; all later samples are tick-aligned.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         rx_state   <= RX_IDLE;
         rx_os      <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par_err <= 1'b0;
      end else begin
         unique case (rx_state)
            RX_IDLE: begin
               if (rx_s_d & ~rx_s) begin
                  rx_state   <= RX_START;
                  rx_os      <= '0;
                  rx_par_err <= 1'b0;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rx_os == OS_MID) begin
                     rx_state <= rx_s ? RX_IDLE : RX_DATA;
                     rx_os    <= '0;
                     rx_bit   <= '0;
                  end else begin
                     rx_os <= rx_os + OS_W'(1);
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (rx_os == OS_LAST) begin
                     rx_os    <= '0;
                     rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                     if (rx_bit == BIT_LAST)
                        rx_state <= par_en ? RX_PARITY : RX_STOP;
                     else
                        rx_bit <= rx_bit + BIT_W'(1);
                  end else begin
                     rx_os <= rx_os + OS_W'(1);
                  end
               end
            end
            RX_PARITY: begin
               if (tick) begin
                  if (rx_os == OS_LAST) begin
                     rx_state   <= RX_STOP;
                     rx_os      <= '0;
                     rx_par_err <= rx_s ^ (^rx_shift) ^ par_odd;
                  end else begin
                     rx_os <= rx_os + OS_W'(1);
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  if (rx_os == OS_LAST)
                     rx_state <= RX_IDLE;
                  else
                     rx_os <= rx_os + OS_W'(1);
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: vector table of loopback
// transfers plus hand-written error, overflow and flow-control sequences.
module tb_uart_fifo_core;

   typedef struct {
      logic [15:0] bd;
      logic [1:0]  pm;
      logic [7:0]  data;
      logic        chk_par;
      logic        exp_par;
      logic [7:0]  exp_data;
      logic [2:0]  exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        nReset;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic [7:0]  tx_wdata;
   logic        tx_wvalid;
   logic        tx_wready;
   logic [7:0]  rx_rdata;
   logic        rx_rvalid;
   logic        rx_rready;
   logic        rx;
   logic        tx;
   logic        cts;
   logic        rts;
   logic [2:0]  err_status;
   logic        err_clr;
   logic        loop;
   logic        rx_drv;

   int checks = 0;
   int errors = 0;
   vec_t vecs [6];

   assign rx = loop ? tx : rx_drv;

   always #5 clk = ~clk;

   uart_fifo_core dut (
      .clk         (clk),
      .nReset      (nReset),
      .baud_div    (baud_div),
      .parity_mode (parity_mode),
      .tx_wdata    (tx_wdata),
      .tx_wvalid   (tx_wvalid),
      .tx_wready   (tx_wready),
      .rx_rdata    (rx_rdata),
      .rx_rvalid   (rx_rvalid),
      .rx_rready   (rx_rready),
      .rx          (rx),
      .tx          (tx),
      .cts         (cts),
      .rts         (rts),
      .err_status  (err_status),
      .err_clr     (err_clr)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] d);
      bit ok = 0;
      for (int i = 0; i < 5000 && !ok; i++) begin
         @(negedge clk);
         if (tx_wready === 1'b1) ok = 1;
      end
      if (!ok) chk("write_timeout", 0, 1);
      tx_wdata  = d;
      tx_wvalid = 1'b1;
      @(negedge clk);
      tx_wvalid = 1'b0;
   endtask

   task automatic wait_tx_fall(input int lim, output bit ok);
      ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         if (tx === 1'b0) ok = 1;
      end
   endtask

   task automatic wait_rvalid(input int lim, output bit ok);
      ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         if (rx_rvalid === 1'b1) ok = 1;
      end
   endtask

   task automatic pop_byte();
      rx_rready = 1'b1;
      @(negedge clk);
      rx_rready = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic count_low(input int n, output int lows);
      lows = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
   endtask

   // Drive one frame on rx_drv, starting at the current negedge.
   task automatic send_frame(input logic [7:0] d, input int bd,
                             input bit with_par, input logic pbit,
                             input logic stopb);
      int bitp = 16 * (bd + 1);
      rx_drv = 1'b0;
      repeat (bitp) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (bitp) @(negedge clk);
      end
      if (with_par) begin
         rx_drv = pbit;
         repeat (bitp) @(negedge clk);
      end
      rx_drv = stopb;
      repeat (bitp) @(negedge clk);
      rx_drv = 1'b1;
      repeat (bitp) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      nReset = 1'b0;
      repeat (2) @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bit ok;
      int n;
      int bitp;
      logic [7:0] a5_bits;
      logic [7:0] b81_bits;

      vecs[0] = '{16'd2, 2'b01, 8'h07, 1'b1, 1'b1, 8'h07, 3'b000};
      vecs[1] = '{16'd0, 2'b00, 8'hA5, 1'b0, 1'b0, 8'hA5, 3'b000};
      vecs[2] = '{16'd1, 2'b10, 8'h3C, 1'b1, 1'b1, 8'h3C, 3'b000};
      vecs[3] = '{16'd3, 2'b01, 8'hFF, 1'b1, 1'b0, 8'hFF, 3'b000};
      vecs[4] = '{16'd0, 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 3'b000};
      vecs[5] = '{16'd1, 2'b10, 8'h80, 1'b1, 1'b0, 8'h80, 3'b000};
      a5_bits  = 8'b1010_0101;
      b81_bits = 8'b1000_0001;

      nReset      = 1'b0;
      baud_div    = 16'd0;
      parity_mode = 2'b00;
      tx_wdata    = 8'h00;
      tx_wvalid   = 1'b0;
      rx_rready   = 1'b0;
      err_clr     = 1'b0;
      cts         = 1'b1;
      loop        = 1'b0;
      rx_drv      = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_rts", rts, 0);
      chk("rst_wready", tx_wready, 0);
      chk("rst_rvalid", rx_rvalid, 0);
      chk("rst_rdata", rx_rdata, 0);
      chk("rst_err", err_status, 0);
      nReset = 1'b1;
      #1;
      chk("wready_at_release", tx_wready, 0);
      @(negedge clk);
      chk("wready_rise", tx_wready, 1);
      chk("rts_rise", rts, 1);

      // 0xA5 waveform at baud_div=0, no parity
      write_byte(8'hA5);
      wait_tx_fall(100, ok);
      chk("a5_fall", ok, 1);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx !== 1'b0) break;
         n++;
      end
      chk("a5_start_len", n, 16);
      repeat (8) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("a5_bit%0d", k), tx, a5_bits[k]);
         repeat (16) @(negedge clk);
      end
      chk("a5_stop", tx, 1);
      repeat (40) @(negedge clk);

      // Loopback vector table
      loop = 1'b1;
      foreach (vecs[v]) begin
         baud_div    = vecs[v].bd;
         parity_mode = vecs[v].pm;
         bitp        = 16 * (int'(vecs[v].bd) + 1);
         repeat (2) @(negedge clk);
         write_byte(vecs[v].data);
         wait_tx_fall(bitp * 3 + 50, ok);
         chk($sformatf("v%0d_fall", v), ok, 1);
         repeat (bitp * 9 + bitp / 2) @(negedge clk);
         if (vecs[v].chk_par)
            chk($sformatf("v%0d_par", v), tx, vecs[v].exp_par);
         wait_rvalid(bitp * 4, ok);
         chk($sformatf("v%0d_rvalid", v), ok, 1);
         chk($sformatf("v%0d_rdata", v), rx_rdata, vecs[v].exp_data);
         chk($sformatf("v%0d_err", v), err_status, vecs[v].exp_err);
         pop_byte();
         chk($sformatf("v%0d_empty", v), rx_rvalid, 0);
         repeat (bitp * 2) @(negedge clk);
      end
      loop = 1'b0;

      // Odd-parity frame while configured for even parity
      baud_div    = 16'd2;
      parity_mode = 2'b01;
      @(negedge clk);
      send_frame(8'h07, 2, 1'b1, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      chk("perr_rvalid", rx_rvalid, 0);
      chk("perr_status", err_status, 3'b010);
      pulse_clr();
      chk("perr_clr", err_status, 3'b000);

      // Stop bit forced low
      parity_mode = 2'b00;
      @(negedge clk);
      send_frame(8'h3C, 2, 1'b0, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("ferr_rvalid", rx_rvalid, 0);
      chk("ferr_status", err_status, 3'b001);
      pulse_clr();
      chk("ferr_clr", err_status, 3'b000);

      // Four-tick glitch must not start a frame
      rx_drv = 1'b0;
      repeat (12) @(negedge clk);
      rx_drv = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch_rvalid", rx_rvalid, 0);
      chk("glitch_err", err_status, 0);
      send_frame(8'h5A, 2, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      chk("post_glitch_rvalid", rx_rvalid, 1);
      chk("post_glitch_rdata", rx_rdata, 8'h5A);
      chk("post_glitch_err", err_status, 0);
      pop_byte();

      // RX overflow: five bytes into a four-entry FIFO
      baud_div    = 16'd0;
      parity_mode = 2'b00;
      loop        = 1'b1;
      repeat (4) @(negedge clk);
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      write_byte(8'h44);
      write_byte(8'h55);
      repeat (6 * 170) @(negedge clk);
      chk("ovf_rts", rts, 0);
      chk("ovf_rvalid", rx_rvalid, 1);
      chk("ovf_status", err_status, 3'b100);
      chk("ovf_head", rx_rdata, 8'h11);
      pulse_clr();
      chk("ovf_clr", err_status, 0);

      // Push and pop in the same clk while full
      loop = 1'b0;
      @(negedge clk);
      fork
         send_frame(8'h66, 0, 1'b0, 1'b0, 1'b1);
         begin
            repeat (154) @(negedge clk);
            rx_rready = 1'b1;
            @(negedge clk);
            rx_rready = 1'b0;
         end
      join
      chk("pp_no_ovf", err_status, 0);
      chk("pp_head", rx_rdata, 8'h22);
      pop_byte();
      @(negedge clk);
      chk("rts_at_3", rts, 0);
      chk("pp_d1", rx_rdata, 8'h33);
      pop_byte();
      @(negedge clk);
      chk("rts_at_2", rts, 1);
      chk("pp_d2", rx_rdata, 8'h44);
      pop_byte();
      chk("pp_d3", rx_rdata, 8'h66);
      pop_byte();
      chk("pp_drained", rx_rvalid, 0);

      // CTS gating, mid-frame CTS drop, mid-frame reset
      do_reset();
      cts = 1'b0;
      write_byte(8'h81);
      write_byte(8'h42);
      count_low(100, n);
      chk("cts_hold", n, 0);
      cts = 1'b1;
      wait_tx_fall(40, ok);
      chk("cts_fall", ok, 1);
      repeat (40) @(negedge clk);
      cts = 1'b0;
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("cts_bit%0d", k), tx, b81_bits[k]);
         repeat (16) @(negedge clk);
      end
      chk("cts_stop", tx, 1);
      count_low(300, n);
      chk("cts_no_second", n, 0);
      cts = 1'b1;
      wait_tx_fall(40, ok);
      chk("cts_second_fall", ok, 1);
      repeat (30) @(negedge clk);
      nReset = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_wready", tx_wready, 0);
      chk("mid_rst_rvalid", rx_rvalid, 0);
      repeat (2) @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      chk("mid_rst_up", tx_wready, 1);
      count_low(200, n);
      chk("mid_rst_fifo_empty", n, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
- Parametrised successor to the tapeout UART datapath.
- Full-duplex UART with a programmable baud divider, selectable parity, TX/RX FIFOs with valid/ready handshakes, RTS/CTS flow control and sticky error reporting.
- Sits behind a bus or pad wrapper; serial side connects to pins, parallel side to a host interface.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..8
FIFO_DEPTH, 4, entries per FIFO, power of two, >=2
DIV_W, 16, width of baud divider input
OVERSAMPLE, 16, ticks per bit period, fixed even value

Ports:
clk  in  1  system clock
nReset  in  1  asynchronous active-low reset
baud_div  in  DIV_W  clk cycles per oversample tick minus 1
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
tx_wdata  in  DATA_BITS  TX FIFO write data
tx_wvalid  in  1  TX write request
tx_wready  out  1  TX FIFO not full
rx_rdata  out  DATA_BITS  RX FIFO head (show-ahead)
rx_rvalid  out  1  RX FIFO not empty
rx_rready  in  1  RX pop
rx  in  1  serial input, asynchronous
tx  out  1  serial output
cts  in  1  peer ready to receive, active high, asynchronous
rts  out  1  we are ready to receive, active high
err_status  out  3  sticky {overflow, parity, frame}
err_clr  in  1  clears err_status

Behaviour:
- Reset (async, nReset low): tx=1, rts=0, tx_wready=0, rx_rvalid=0, rx_rdata=0, err_status=0, FIFOs emptied, FSMs to IDLE, tick counter 0. Mid-frame reset aborts the frame; tx returns to 1 immediately.
- tx_wready rises 1 clk after nReset deasserts. rts=1 at the same point.
- Tick counter counts 0..baud_div, pulses tick on terminal count, then wraps to 0. Bit period = OVERSAMPLE*(baud_div+1) clks. baud_div=0 is legal (tick every clk).
- rx and cts each pass through a 2-flop synchroniser.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Leaves IDLE on a tick when the FIFO is non-empty and synced cts=1; pops the FIFO at that point.
  - Each state lasts OVERSAMPLE ticks. Data is sent LSB first. PARITY is skipped when parity is none. STOP is 1 bit.
  - cts dropping mid-frame does not abort; the current frame completes.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START on a synced falling edge. START re-samples at tick OVERSAMPLE/2. If high there: false start, return to IDLE, no error.
  - Subsequent samples are taken every OVERSAMPLE ticks, so at mid-bit.
  - STOP sampled 0: frame error. Parity mismatch: parity error.
  - An errored byte is discarded and its flag set.
  - A good byte is pushed at the STOP sample. If the FIFO is full, the byte is dropped and overflow is set.
- Push and pop in the same clk on a full RX FIFO: both occur, count is unchanged, no overflow.
- tx_wvalid while tx_wready=0 is ignored, with no side effect.
- rts = registered (RX count <= FIFO_DEPTH-2), leaving one slack entry for an in-flight frame.
- err_status bits are set on the event clk and held until err_clr. A set and a clear in the same clk: set wins.
- parity_mode and baud_div must be stable while a frame is in flight. They are sampled every clk, with no shadowing.
- Width rules:
  - Parity is computed over DATA_BITS only: even means the total number of 1s in data+parity is even.
  - Data bits above DATA_BITS are never transmitted or received.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_t enum
  - tx_state_t and rx_state_t enums
  - ERR_FRAME=0, ERR_PARITY=1, ERR_OVERFLOW=2 index constants
- Sub-module uart_sync_fifo (params WIDTH, DEPTH; ports push, pop, wdata, rdata, full, empty, count) is instantiated twice.
- Tick generator, TX FSM and RX FSM stay inline.

Test Plan:
- baud_div=0, parity none, cts=1, write 0xA5 -> tx low for 16 clks, then 1,0,1,0,0,1,0,1 at 16 clks each, then stop high; frame = 160 clks.
- Loopback rx=tx, parity even, baud_div=2, write 0x07 -> parity bit 1, rx_rdata=0x07, rx_rvalid=1, err_status=0.
- Inject odd-parity frame of 0x07 while configured even -> no RX push, err_status=3'b010. err_clr -> 3'b000.
- Stop bit forced 0 on 0x3C -> frame dropped, err_status=3'b001. A 4-tick low glitch on rx -> no START, no error.
- Loopback, DEPTH=4, rx_rready=0, send 5 bytes -> rts=0 once count reaches 3, 5th byte dropped, err_status[2]=1. Pop and push in the same clk at full -> no overflow.
- cts=0 with 2 bytes queued -> tx stays 1. Raise cts, then drop it mid first frame -> first frame completes, second does not start. Assert nReset mid-frame -> tx=1, FIFOs empty.
